// File: rtl/fmps_gather_links_pkg.sv
// Shared definitions for the FMPS status gatherer: status codes, FSM
// encoding and the link-number width helper.
package fmps_gather_links_pkg;

    // Status code carried by a successful FMPS event.
    localparam logic [1:0] ST_SUCCESS = 2'd0;

    // Per-FA-cycle readout state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } fsmState_t;

    // Width of a link number; a single link still needs one bit of storage.
    function automatic int linkWidth(input int numLinks);
        return (numLinks > 1) ? $clog2(numLinks) : 1;
    endfunction

endpackage

// File: rtl/fmps_rr_arbiter.sv
// Round-robin arbiter: grants at most one requesting link per cycle,
// searching from the link after the last one granted.
module fmps_rr_arbiter
    import fmps_gather_links_pkg::*;
#(
    parameter  int NUM_LINKS = 2,
    localparam int LINK_W    = linkWidth(NUM_LINKS)
) (
    input  logic                 sysClk,
    input  logic                 sysResetN,
    input  logic [NUM_LINKS-1:0] request,
    output logic [NUM_LINKS-1:0] grant,
    output logic                 grantValid,
    output logic [LINK_W-1:0]    grantIdx
);

    logic [LINK_W-1:0] lastGrant;
    logic [LINK_W-1:0] cand;

    // Pick the first requester after lastGrant, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before the search so no path leaves it unassigned (no latch).
        grant      = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_LINKS; i++) begin
            cand = LINK_W'((int'(lastGrant) + i) % NUM_LINKS);
            if (!grantValid && request[cand]) begin
                grant[cand] = 1'b1;
                grantValid  = 1'b1;
                grantIdx    = cand;
            end
        end
    end

    // Remember the winner so the next search starts just after it.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!sysResetN) begin
            lastGrant <= '0;
        end else if (grantValid) begin
            lastGrant <= grantIdx;
        end
    end

endmodule

// File: rtl/fmps_gather_links.sv
// FMPS status gatherer: merges NUM_LINKS status streams, tracks received and
// enabled nodes per FA cycle, declares completion or timeout and records the
// link that first delivered each node.
module fmps_gather_links
    import fmps_gather_links_pkg::*;
#(
    parameter  int SYSCLK_RATE = 100000000,
    parameter  int INDEX_WIDTH = 5,
    parameter  int NUM_LINKS   = 2,
    parameter  int TIMER_WIDTH = 8,
    parameter  int SEQNO_WIDTH = 3,
    localparam int NODES       = 2**INDEX_WIDTH,
    localparam int LINK_W      = linkWidth(NUM_LINKS),
    localparam int ERR_W       = $clog2(NUM_LINKS) + 2
) (
    input  logic                       sysClk,
    input  logic                       sysResetN,
    input  logic                       FAstrobe,
    input  logic [INDEX_WIDTH:0]       expectedCount,
    input  logic [TIMER_WIDTH-1:0]     timeoutUs,
    input  logic [NUM_LINKS-1:0]       linkEnable,
    input  logic [NUM_LINKS-1:0]       stVALID,
    output logic [NUM_LINKS-1:0]       stREADY,
    input  logic [NUM_LINKS*INDEX_WIDTH-1:0] stINDEX,
    input  logic [NUM_LINKS*2-1:0]     stCODE,
    input  logic [NUM_LINKS-1:0]       stENABLED,
    output logic [NODES-1:0]           fmpsBitmapAll,
    output logic [NODES-1:0]           fmpsBitmapEnabled,
    output logic [NODES-1:0]           fmpsBitmapAllSnapshot,
    output logic [NODES-1:0]           fmpsBitmapEnabledSnapshot,
    output logic                       fmpsEnabled,
    output logic                       readoutActive,
    output logic                       readoutValid,
    output logic                       readTimeout,
    output logic                       timeoutStrobe,
    output logic                       lateStrobe,
    output logic                       errorStrobe,
    output logic [ERR_W-1:0]           errorCode,
    output logic [TIMER_WIDTH-1:0]     readoutTime,
    output logic [SEQNO_WIDTH-1:0]     seqno,
    input  logic [INDEX_WIDTH-1:0]     readoutAddress,
    output logic [LINK_W-1:0]          readoutLink,
    output logic                       readoutPresent
);

    localparam int CYCLES_PER_US = SYSCLK_RATE / 1000000;
    localparam int PRESCALE_W    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LOAD = PRESCALE_W'(CYCLES_PER_US - 1);

    fsmState_t              state, stateNext;
    logic                   completionHit, timeoutHit;
    logic [NUM_LINKS-1:0]   request, grant;
    logic                   grantValid;
    logic [LINK_W-1:0]      grantIdx;
    logic [INDEX_WIDTH-1:0] selIndex;
    logic [1:0]             selCode;
    logic                   selEnabled;
    logic                   acceptSuccess, acceptError, firstArrival;
    logic [INDEX_WIDTH:0]   allCount, enabledCount;
    logic [PRESCALE_W-1:0]  prescaler;
    logic [TIMER_WIDTH-1:0] timer;
    logic [LINK_W-1:0]      origin [NODES];

    // Disabled links are held out of arbitration; nothing is accepted on an FA edge.
    assign request = stVALID & linkEnable & {NUM_LINKS{~FAstrobe}};

    fmps_rr_arbiter #(.NUM_LINKS(NUM_LINKS)) arbiter (
        .sysClk     (sysClk),
        .sysResetN  (sysResetN),
        .request    (request),
        .grant      (grant),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    // Disabled links are always ready so their sources drain into nowhere.
    assign stREADY = FAstrobe ? '0 : (grant | ~linkEnable);

    // Route the granted link's event fields onto one bus.
    always_comb begin
        selIndex   = '0;
        selCode    = ST_SUCCESS;
        selEnabled = 1'b0;
        for (int k = 0; k < NUM_LINKS; k++) begin
            if (grant[k]) begin
                selIndex   = stINDEX[k*INDEX_WIDTH +: INDEX_WIDTH];
                selCode    = stCODE[k*2 +: 2];
                selEnabled = stENABLED[k];
            end
        end
    end

    assign acceptSuccess = grantValid && (selCode == ST_SUCCESS);
    assign acceptError   = grantValid && (selCode != ST_SUCCESS);
    assign firstArrival  = (state == ACTIVE) && acceptSuccess && !fmpsBitmapAll[selIndex];

    // Next-state logic; FAstrobe restarts from anywhere, completion beats timeout.
    always_comb begin
        stateNext     = state;
        completionHit = 1'b0;
        timeoutHit    = 1'b0;
        if (FAstrobe) begin
            stateNext = ACTIVE;
        end else if (state == ACTIVE) begin
            if (allCount == expectedCount) begin
                stateNext     = DONE;
                completionHit = 1'b1;
            end else if ((timeoutUs != '0) && (timer == timeoutUs)) begin
                stateNext  = TIMEOUT;
                timeoutHit = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) state <= IDLE;
        else            state <= stateNext;
    end

    // Node bitmaps, distinct-node counters and snapshots.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            fmpsBitmapAll             <= '0;
            fmpsBitmapEnabled         <= '0;
            fmpsBitmapAllSnapshot     <= '0;
            fmpsBitmapEnabledSnapshot <= '0;
            allCount                  <= '0;
            enabledCount              <= '0;
        end else if (FAstrobe) begin
            fmpsBitmapAllSnapshot     <= fmpsBitmapAll;
            fmpsBitmapEnabledSnapshot <= fmpsBitmapEnabled;
            fmpsBitmapAll             <= '0;
            fmpsBitmapEnabled         <= '0;
            allCount                  <= '0;
            enabledCount              <= '0;
        end else if ((state == ACTIVE) && acceptSuccess) begin
            if (!fmpsBitmapAll[selIndex]) begin
                fmpsBitmapAll[selIndex] <= 1'b1;
                allCount                <= allCount + 1'b1;
            end
            if (selEnabled && !fmpsBitmapEnabled[selIndex]) begin
                fmpsBitmapEnabled[selIndex] <= 1'b1;
                enabledCount                <= enabledCount + 1'b1;
            end
        end
    end

    // Link-of-origin table, written on a node's first arrival only.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        // NOTE: this table is small and must read back 0 after reset, so it is reset explicitly rather than left as RAM.
        if (!sysResetN) begin
            for (int n = 0; n < NODES; n++) origin[n] <= '0;
        end else if (firstArrival) begin
            origin[selIndex] <= grantIdx;
        end
    end

    // Microsecond prescaler and saturating timer, running while ACTIVE.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (FAstrobe) begin
            prescaler <= PRESCALE_LOAD;
            timer     <= '0;
        end else if (state == ACTIVE) begin
            if (prescaler == '0) begin
                prescaler <= PRESCALE_LOAD;
                if (timer != '1) timer <= timer + 1'b1;
            end else begin
                prescaler <= prescaler - 1'b1;
            end
        end
    end

    // Readout status flags, result latches and event strobes.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            readoutActive <= 1'b0;
            readoutValid  <= 1'b0;
            readTimeout   <= 1'b0;
            fmpsEnabled   <= 1'b0;
            readoutTime   <= '0;
            seqno         <= '0;
            timeoutStrobe <= 1'b0;
            lateStrobe    <= 1'b0;
            errorStrobe   <= 1'b0;
            errorCode     <= '0;
        end else begin
            timeoutStrobe <= timeoutHit;
            lateStrobe    <= acceptSuccess && (state != ACTIVE);
            errorStrobe   <= acceptError;
            if (acceptError) errorCode <= ERR_W'({grantIdx, selCode});
            if (FAstrobe) begin
                readoutActive <= 1'b1;
                readoutValid  <= 1'b0;
                readTimeout   <= 1'b0;
            end else if (completionHit) begin
                readoutActive <= 1'b0;
                readoutValid  <= 1'b1;
                fmpsEnabled   <= (enabledCount == expectedCount);
                seqno         <= seqno + 1'b1;
                readoutTime   <= timer;
            end else if (timeoutHit) begin
                readoutActive <= 1'b0;
                readTimeout   <= 1'b1;
                fmpsEnabled   <= 1'b0;
                readoutTime   <= timer;
            end
        end
    end

    // Registered per-node readout of presence and origin link.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            readoutPresent <= 1'b0;
            readoutLink    <= '0;
        end else begin
            readoutPresent <= readoutValid && fmpsBitmapAll[readoutAddress];
            readoutLink    <= (readoutValid && fmpsBitmapAll[readoutAddress])
                              ? origin[readoutAddress] : '0;
        end
    end

endmodule

// File: tb/tb_fmps_gather_links.sv
// Directed self-checking bench for fmps_gather_links (two links, 100 MHz).
module tb_fmps_gather_links;

    logic        sysClk;
    logic        sysResetN;
    logic        FAstrobe;
    logic [5:0]  expectedCount;
    logic [7:0]  timeoutUs;
    logic [1:0]  linkEnable;
    logic [1:0]  stVALID;
    logic [1:0]  stREADY;
    logic [9:0]  stINDEX;
    logic [3:0]  stCODE;
    logic [1:0]  stENABLED;
    logic [31:0] fmpsBitmapAll, fmpsBitmapEnabled;
    logic [31:0] fmpsBitmapAllSnapshot, fmpsBitmapEnabledSnapshot;
    logic        fmpsEnabled, readoutActive, readoutValid, readTimeout;
    logic        timeoutStrobe, lateStrobe, errorStrobe;
    logic [2:0]  errorCode;
    logic [7:0]  readoutTime;
    logic [2:0]  seqno;
    logic [4:0]  readoutAddress;
    logic [0:0]  readoutLink;
    logic        readoutPresent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fmps_gather_links dut (
        .sysClk                    (sysClk),
        .sysResetN                 (sysResetN),
        .FAstrobe                  (FAstrobe),
        .expectedCount             (expectedCount),
        .timeoutUs                 (timeoutUs),
        .linkEnable                (linkEnable),
        .stVALID                   (stVALID),
        .stREADY                   (stREADY),
        .stINDEX                   (stINDEX),
        .stCODE                    (stCODE),
        .stENABLED                 (stENABLED),
        .fmpsBitmapAll             (fmpsBitmapAll),
        .fmpsBitmapEnabled         (fmpsBitmapEnabled),
        .fmpsBitmapAllSnapshot     (fmpsBitmapAllSnapshot),
        .fmpsBitmapEnabledSnapshot (fmpsBitmapEnabledSnapshot),
        .fmpsEnabled               (fmpsEnabled),
        .readoutActive             (readoutActive),
        .readoutValid              (readoutValid),
        .readTimeout               (readTimeout),
        .timeoutStrobe             (timeoutStrobe),
        .lateStrobe                (lateStrobe),
        .errorStrobe               (errorStrobe),
        .errorCode                 (errorCode),
        .readoutTime               (readoutTime),
        .seqno                     (seqno),
        .readoutAddress            (readoutAddress),
        .readoutLink               (readoutLink),
        .readoutPresent            (readoutPresent)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic tickc();
        tick();
        cyc++;
    endtask

    task automatic setLink(input int link, input logic [4:0] idx, input logic [1:0] code,
                           input logic en, input logic v);
        stINDEX[link*5 +: 5] = idx;
        stCODE[link*2 +: 2]  = code;
        stENABLED[link]      = en;
        stVALID[link]        = v;
    endtask

    // Present one event on an uncontended link for a single cycle.
    task automatic offer(input int link, input logic [4:0] idx, input logic [1:0] code, input logic en);
        setLink(link, idx, code, en, 1'b1);
        tick();
        stVALID[link] = 1'b0;
    endtask

    task automatic pulseFA();
        FAstrobe = 1'b1;
        tick();
        FAstrobe = 1'b0;
    endtask

    initial begin
        sysResetN      = 1'b0;
        FAstrobe       = 1'b0;
        expectedCount  = 6'd3;
        timeoutUs      = 8'd0;
        linkEnable     = 2'b11;
        stVALID        = 2'b00;
        stINDEX        = '0;
        stCODE         = '0;
        stENABLED      = '0;
        readoutAddress = '0;

        // Reset state
        #23;
        check("reset_bitmap", fmpsBitmapAll, 32'h0);
        check("reset_active", readoutActive, 1'b0);
        check("reset_valid", readoutValid, 1'b0);
        check("reset_seqno", seqno, 3'd0);
        sysResetN = 1'b1;
        tick();
        tick();

        // Completion: nodes 1,4,7 on link0, all enabled
        pulseFA();
        check("fa_active", readoutActive, 1'b1);
        offer(0, 5'd1, 2'd0, 1'b1);
        offer(0, 5'd4, 2'd0, 1'b1);
        offer(0, 5'd7, 2'd0, 1'b1);
        check("c1_bitmap", fmpsBitmapAll, 32'h92);
        check("c1_not_yet_valid", readoutValid, 1'b0);
        tick();
        check("c1_valid", readoutValid, 1'b1);
        check("c1_enabled", fmpsEnabled, 1'b1);
        check("c1_seqno", seqno, 3'd1);
        check("c1_active_clr", readoutActive, 1'b0);
        check("c1_time", readoutTime, 8'd0);
        check("c1_bitmap_en", fmpsBitmapEnabled, 32'h92);
        readoutAddress = 5'd4;
        tick();
        check("c1_rd_present", readoutPresent, 1'b1);
        check("c1_rd_link", readoutLink, 1'b0);
        readoutAddress = 5'd2;
        tick();
        check("c1_rd_absent", readoutPresent, 1'b0);

        // Late success event after DONE
        offer(0, 5'd9, 2'd0, 1'b1);
        check("late_strobe", lateStrobe, 1'b1);
        check("late_no_err", errorStrobe, 1'b0);
        check("late_bitmap", fmpsBitmapAll, 32'h92);
        tick();
        check("late_pulse", lateStrobe, 1'b0);

        // Error event on link1, code 2 (pointer now at link1)
        offer(1, 5'd3, 2'd2, 1'b1);
        check("err_strobe", errorStrobe, 1'b1);
        check("err_code", errorCode, 3'b110);
        check("err_bitmap", fmpsBitmapAll, 32'h92);
        check("err_no_late", lateStrobe, 1'b0);

        // Contention on node 5, pointer at link1 so link0 wins first
        pulseFA();
        check("snap_all", fmpsBitmapAllSnapshot, 32'h92);
        check("snap_en", fmpsBitmapEnabledSnapshot, 32'h92);
        check("fa_clear", fmpsBitmapAll, 32'h0);
        check("fa_valid_clr", readoutValid, 1'b0);
        setLink(0, 5'd5, 2'd0, 1'b1, 1'b1);
        setLink(1, 5'd5, 2'd0, 1'b1, 1'b1);
        #1;
        check("rr_grant0", stREADY, 2'b01);
        tick();
        stVALID[0] = 1'b0;
        #1;
        check("rr_grant1", stREADY, 2'b10);
        check("rr_bitmap", fmpsBitmapAll, 32'h20);
        tick();
        stVALID[1] = 1'b0;
        offer(0, 5'd10, 2'd0, 1'b0);
        offer(0, 5'd11, 2'd0, 1'b1);
        check("dup_not_counted", readoutValid, 1'b0);
        tick();
        check("c2_valid", readoutValid, 1'b1);
        check("c2_seqno", seqno, 3'd2);
        check("c2_enabled", fmpsEnabled, 1'b0);
        check("c2_bitmap", fmpsBitmapAll, 32'hC20);
        check("c2_bitmap_en", fmpsBitmapEnabled, 32'h820);
        readoutAddress = 5'd5;
        tick();
        check("c2_rd_present", readoutPresent, 1'b1);
        check("c2_rd_link0", readoutLink, 1'b0);

        // Repeat with pointer at link0 so link1 wins; expectedCount=1
        expectedCount = 6'd1;
        pulseFA();
        setLink(0, 5'd5, 2'd0, 1'b1, 1'b1);
        setLink(1, 5'd5, 2'd0, 1'b1, 1'b1);
        #1;
        check("rr2_grant1", stREADY, 2'b10);
        tick();
        stVALID[1] = 1'b0;
        #1;
        check("rr2_grant0", stREADY, 2'b01);
        tick();
        stVALID[0] = 1'b0;
        check("c3_valid", readoutValid, 1'b1);
        check("c3_seqno", seqno, 3'd3);
        check("c3_enabled", fmpsEnabled, 1'b1);
        tick();
        check("c3_rd_present", readoutPresent, 1'b1);
        check("c3_rd_link1", readoutLink, 1'b1);

        // Link1 disabled, events offered during FA, then timeout at 3 us
        linkEnable    = 2'b01;
        expectedCount = 6'd4;
        timeoutUs     = 8'd3;
        FAstrobe      = 1'b1;
        setLink(0, 5'd2, 2'd0, 1'b1, 1'b1);
        setLink(1, 5'd3, 2'd0, 1'b1, 1'b1);
        #1;
        check("fa_ready_low", stREADY, 2'b00);
        tick();
        FAstrobe = 1'b0;
        cyc = 0;
        #1;
        check("held_and_disabled_ready", stREADY, 2'b11);
        tickc();
        setLink(0, 5'd6, 2'd0, 1'b1, 1'b1);
        stVALID[1] = 1'b0;
        tickc();
        stVALID[0] = 1'b0;
        check("dis_bitmap", fmpsBitmapAll, 32'h44);
        check("dis_no_err", errorStrobe, 1'b0);
        check("dis_no_late", lateStrobe, 1'b0);
        while (!timeoutStrobe && cyc < 400) tickc();
        check("to_seen", timeoutStrobe, 1'b1);
        check("to_cycle_window", (cyc >= 299 && cyc <= 302), 1'b1);
        check("to_flag", readTimeout, 1'b1);
        check("to_time", readoutTime, 8'd3);
        check("to_enabled_clr", fmpsEnabled, 1'b0);
        check("to_seqno", seqno, 3'd3);
        check("to_not_valid", readoutValid, 1'b0);
        tick();
        check("to_pulse", timeoutStrobe, 1'b0);

        // Asynchronous reset in ACTIVE with two nodes received
        linkEnable    = 2'b11;
        timeoutUs     = 8'd0;
        expectedCount = 6'd4;
        pulseFA();
        offer(0, 5'd1, 2'd0, 1'b1);
        offer(0, 5'd2, 2'd0, 1'b1);
        check("pre_rst_bitmap", fmpsBitmapAll, 32'h06);
        check("pre_rst_active", readoutActive, 1'b1);
        #3;
        sysResetN = 1'b0;
        #1;
        check("rst_bitmap", fmpsBitmapAll, 32'h0);
        check("rst_active", readoutActive, 1'b0);
        check("rst_seqno", seqno, 3'd0);
        check("rst_snapshot", fmpsBitmapAllSnapshot, 32'h0);
        check("rst_errcode", errorCode, 3'd0);
        check("rst_readtime", readoutTime, 8'd0);
        check("rst_timeout", readTimeout, 1'b0);
        #2;
        sysResetN = 1'b1;
        tick();
        expectedCount = 6'd1;
        pulseFA();
        offer(0, 5'd8, 2'd0, 1'b1);
        tick();
        check("restart_valid", readoutValid, 1'b1);
        check("restart_seqno", seqno, 3'd1);
        check("restart_bitmap", fmpsBitmapAll, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
